// File: rtl/alu_rst_pkg.sv
// Shared types and defaults for the ALU reset controller.
package alu_rst_pkg;

    localparam int DEF_N_REQ      = 2;
    localparam int DEF_DUR_W      = 8;
    localparam int DEF_POR_CYCLES = 4;
    localparam int DEF_HOLDOFF    = 2;
    localparam int DEF_CNT_W      = 16;

    // Controller phases: power-on hold, waiting for a request,
    // driving a granted reset, and the quiet window after a reset.
    typedef enum logic [1:0] {
        ST_POR     = 2'd0,
        ST_IDLE    = 2'd1,
        ST_ASSERT  = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_e;

    // A requested duration of zero still produces one low cycle.
    function automatic int unsigned clamp_dur(input int unsigned dur);
        return (dur == 0) ? 32'd1 : dur;
    endfunction

endpackage

// File: rtl/alu_rst_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above the
// pointer, wrapping around. The pointer register lives in the parent.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int PTR_W = 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic             valid_o
);

    // Walk priority offsets from the pointer; the first requester hit wins.
    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!valid_o && req_i[i] && (i == ((int'(ptr_i) + k) % N_REQ))) begin
                    grant_o[i] = 1'b1;
                    valid_o    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_rst_ctrl.sv
// Reset controller for the ALU datapath: power-on reset, round-robin
// granting of timed reset requests, post-reset holdoff, issued-reset count.
//
// Request handshake: a requester raises req[i] with req_dur[i] valid and
// holds both until it sees its one-cycle gnt[i] pulse; the duration is
// captured on the grant edge only. Dropping req before the grant withdraws
// the request. Requests are only arbitrated in IDLE.
module alu_rst_ctrl
    import alu_rst_pkg::*;
#(
    parameter int N_REQ      = DEF_N_REQ,
    parameter int DUR_W      = DEF_DUR_W,
    parameter int POR_CYCLES = DEF_POR_CYCLES,
    parameter int HOLDOFF    = DEF_HOLDOFF,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*DUR_W-1:0] req_dur,
    output logic [N_REQ-1:0]       gnt,
    output logic                   alu_rst_n,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       reset_count,
    output state_e                 dbg_state_o
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW_P  = $clog2(POR_CYCLES + 1);
    localparam int CW_H  = $clog2(HOLDOFF + 1);
    localparam int CW_PH = (CW_P > CW_H) ? CW_P : CW_H;
    // One down-counter serves POR, ASSERT and HOLDOFF phases.
    localparam int CW    = (DUR_W > CW_PH) ? DUR_W : CW_PH;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [N_REQ-1:0]     gnt_q, gnt_d;
    logic                 done_q, done_d;
    logic                 alu_rst_n_q, alu_rst_n_d;
    logic [CNT_W-1:0]     count_q, count_d;

    logic [N_REQ-1:0]     arb_grant;
    logic                 arb_valid;
    logic [PTR_W-1:0]     win_idx;
    logic [DUR_W-1:0]     win_dur;
    logic [PTR_W-1:0]     ptr_next;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .valid_o (arb_valid)
    );

    // Decode the winner's index and requested duration from the one-hot grant.
    always_comb begin
        win_idx = '0;
        win_dur = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_grant[i]) begin
                win_idx = PTR_W'(i);
                win_dur = req_dur[i*DUR_W +: DUR_W];
            end
        end
        ptr_next = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
    end

    // Next-state logic for the phase sequencer, grant/done pulses and count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gnt_d   = '0;
        done_d  = 1'b0;
        count_d = count_q;
        case (state_q)
            ST_POR: begin
                if (cnt_q <= CW'(1)) begin
                    state_d = (HOLDOFF == 0) ? ST_IDLE : ST_HOLDOFF;
                    cnt_d   = CW'(HOLDOFF);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_IDLE: begin
                if (arb_valid) begin
                    state_d = ST_ASSERT;
                    gnt_d   = arb_grant;
                    cnt_d   = CW'(clamp_dur(32'(win_dur)));
                    ptr_d   = ptr_next;
                    count_d = (count_q == '1) ? count_q : count_q + CNT_W'(1);
                end
            end
            ST_ASSERT: begin
                if (cnt_q <= CW'(1)) begin
                    state_d = (HOLDOFF == 0) ? ST_IDLE : ST_HOLDOFF;
                    cnt_d   = CW'(HOLDOFF);
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_HOLDOFF: begin
                if (cnt_q <= CW'(1)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_POR;
                cnt_d   = CW'(POR_CYCLES);
            end
        endcase
        // The ALU reset is low exactly while the next phase is POR or ASSERT.
        alu_rst_n_d = !((state_d == ST_POR) || (state_d == ST_ASSERT));
    end

    // State registers; controller reset forces the power-on values at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_POR;
            cnt_q       <= CW'(POR_CYCLES);
            ptr_q       <= '0;
            gnt_q       <= '0;
            done_q      <= 1'b0;
            alu_rst_n_q <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            alu_rst_n_q <= alu_rst_n_d;
            count_q     <= count_d;
        end
    end

    assign gnt         = gnt_q;
    assign done        = done_q;
    assign alu_rst_n   = alu_rst_n_q;
    assign busy        = (state_q != ST_IDLE);
    assign reset_count = count_q;
    assign dbg_state_o = state_q;

endmodule
